// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: bundle layouts and request FSM states.
package mem_stage_pkg;

  localparam int unsigned MEM_IN_W  = 104;
  localparam int unsigned WB_OUT_W  = 70;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

  // Field order fixes the bit offsets of the EX->MEM bundle (pc in the MSBs, gr_we at bit 0).
  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      rkd_value;
    logic                 mem_we;
    logic                 res_from_mem;
    logic [REG_IDX_W-1:0] dest;
    logic                 gr_we;
  } mem_in_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      final_result;
    logic [REG_IDX_W-1:0] dest;
    logic                 gr_we;
  } wb_out_t;

  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return {byte_addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-SRAM request/response port: req/addr_ok address phase, data_ok response phase.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic            req;
  logic            wr;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            addr_ok;
  logic            data_ok;
  logic [XLEN-1:0] rdata;

  modport master (output req, wr, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/mem_stage_mem_req_fsm.sv
// Sequences one data-SRAM transaction per captured memory bundle and holds the returned load data.
module mem_stage_mem_req_fsm
  import mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            capture_i,
  input  logic            in_valid_i,
  input  logic            in_is_mem_i,
  input  logic            cur_is_mem_i,
  input  logic            addr_ok_i,
  input  logic            data_ok_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            req_c,
  output logic            ready_go_c,
  output logic [XLEN-1:0] load_data_o
);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] load_data_q, load_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
    end
  end

  // Capture can only happen once the previous op is done, so it overrides the hold states.
  always_comb begin
    state_d     = state_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_REQ:  if (addr_ok_i) state_d = ST_WAIT;
      ST_WAIT: if (data_ok_i) begin
        state_d     = ST_DONE;
        load_data_d = rdata_i;
      end
      default: ;
    endcase
    if (capture_i) state_d = (in_valid_i && in_is_mem_i) ? ST_REQ : ST_IDLE;
  end

  always_comb begin
    req_c      = 1'b0;
    ready_go_c = ~cur_is_mem_i;
    if (state_q == ST_REQ)  req_c      = 1'b1;
    if (state_q == ST_DONE) ready_go_c = 1'b1;
  end

  assign load_data_o = load_data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bundle, runs word loads/stores, forwards the result to WB.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EX_to_MEM_valid,
  input  logic [MEM_IN_W-1:0]  to_MEM_data,
  output logic                 MEM_allow_in,
  input  logic                 WB_allow_in,
  output logic                 MEM_to_WB_valid,
  output logic [WB_OUT_W-1:0]  to_WB_data,
  mem_stage_if.master          data_sram,
  output logic                 fwd_valid,
  output logic [REG_IDX_W-1:0] fwd_dest,
  output logic [XLEN-1:0]      fwd_value,
  output logic                 fwd_stall
);

  logic            mem_valid_q, mem_valid_d;
  mem_in_t         bundle_q, bundle_d;
  mem_in_t         in_bundle;
  wb_out_t         wb_out;
  logic            is_mem, in_is_mem, ready_go, req;
  logic [XLEN-1:0] load_data, final_result;

  assign in_bundle = to_MEM_data;
  assign in_is_mem = in_bundle.mem_we | in_bundle.res_from_mem;
  assign is_mem    = bundle_q.mem_we | bundle_q.res_from_mem;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      mem_valid_q <= mem_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  always_comb begin
    mem_valid_d = mem_valid_q;
    bundle_d    = bundle_q;
    if (MEM_allow_in) mem_valid_d = EX_to_MEM_valid;
    if (MEM_allow_in && EX_to_MEM_valid) bundle_d = in_bundle;
  end

  assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
  assign MEM_to_WB_valid = mem_valid_q & ready_go;

  mem_stage_mem_req_fsm u_req_fsm (
    .clk          (clk),
    .reset        (reset),
    .capture_i    (MEM_allow_in),
    .in_valid_i   (EX_to_MEM_valid),
    .in_is_mem_i  (in_is_mem),
    .cur_is_mem_i (is_mem),
    .addr_ok_i    (data_sram.addr_ok),
    .data_ok_i    (data_sram.data_ok),
    .rdata_i      (data_sram.rdata),
    .req_c        (req),
    .ready_go_c   (ready_go),
    .load_data_o  (load_data)
  );

  // Request fields come straight from the held bundle, so they stay stable until addr_ok.
  assign data_sram.req   = req;
  assign data_sram.wr    = bundle_q.mem_we;
  assign data_sram.addr  = word_addr(bundle_q.alu_result);
  assign data_sram.wdata = bundle_q.rkd_value;

  assign final_result = bundle_q.res_from_mem ? load_data : bundle_q.alu_result;

  assign wb_out.pc           = bundle_q.pc;
  assign wb_out.final_result = final_result;
  assign wb_out.dest         = bundle_q.dest;
  assign wb_out.gr_we        = bundle_q.gr_we;
  assign to_WB_data          = wb_out;

  assign fwd_valid = mem_valid_q & bundle_q.gr_we & (bundle_q.dest != '0);
  assign fwd_dest  = bundle_q.dest;
  assign fwd_value = final_result;
  assign fwd_stall = fwd_valid & bundle_q.res_from_mem & ~ready_go;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboard of expected WB bundles plus a data-SRAM responder model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 ex_valid;
  logic [MEM_IN_W-1:0]  to_mem;
  logic                 mem_allow_in;
  logic                 wb_allow_in;
  logic                 wb_valid;
  logic [WB_OUT_W-1:0]  to_wb;
  logic                 fwd_valid;
  logic [REG_IDX_W-1:0] fwd_dest;
  logic [XLEN-1:0]      fwd_value;
  logic                 fwd_stall;

  mem_stage_if sram ();

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .EX_to_MEM_valid (ex_valid),
    .to_MEM_data     (to_mem),
    .MEM_allow_in    (mem_allow_in),
    .WB_allow_in     (wb_allow_in),
    .MEM_to_WB_valid (wb_valid),
    .to_WB_data      (to_wb),
    .data_sram       (sram),
    .fwd_valid       (fwd_valid),
    .fwd_dest        (fwd_dest),
    .fwd_value       (fwd_value),
    .fwd_stall       (fwd_stall)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  wb_out_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic mem_in_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                 input logic [31:0] rkd, input logic we, input logic rfm,
                                 input logic [4:0] dest, input logic grwe);
    mem_in_t b;
    b.pc = pc; b.alu_result = alu; b.rkd_value = rkd;
    b.mem_we = we; b.res_from_mem = rfm; b.dest = dest; b.gr_we = grwe;
    return b;
  endfunction

  // Data-SRAM responder: addr_ok after addr_dly stalled req cycles, data_ok data_dly cycles after handshake.
  int          addr_dly  = 0;
  int          data_dly  = 1;
  logic [31:0] mem_rdata = '0;
  int          req_wait  = 0;
  int          data_cnt  = 0;
  int          hs_count  = 0;
  bit          pending = 0, last_hs = 0, last_dok = 0, last_stall = 0;
  logic        last_wr = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;

  initial begin
    sram.addr_ok = 1'b0;
    sram.data_ok = 1'b0;
    sram.rdata   = 32'hBAD0_BAD0;
  end

  always @(negedge clk) begin
    if (reset) begin
      pending = 0; last_hs = 0; last_dok = 0; last_stall = 0;
      req_wait = 0; data_cnt = 0;
      sram.addr_ok = 1'b0; sram.data_ok = 1'b0; sram.rdata = 32'hBAD0_BAD0;
    end else begin
      if (last_dok) pending = 0;
      if (pending) data_cnt++;
      if (last_hs) begin pending = 1; data_cnt = 1; req_wait = 0; end
      if (last_stall && sram.req)
        chk("req_fields_stable", 70'({sram.wr, sram.addr, sram.wdata}),
            70'({last_wr, last_addr, last_wdata}));
      sram.addr_ok = 1'b0; sram.data_ok = 1'b0; sram.rdata = 32'hBAD0_BAD0;
      if (pending && data_cnt >= data_dly) begin sram.data_ok = 1'b1; sram.rdata = mem_rdata; end
      if (sram.req && !pending && req_wait >= addr_dly) sram.addr_ok = 1'b1;
      last_hs    = sram.req && sram.addr_ok;
      last_dok   = sram.data_ok;
      last_stall = sram.req && !sram.addr_ok;
      if (last_hs) hs_count++;
      if (last_stall) req_wait++;
      last_wr = sram.wr; last_addr = sram.addr; last_wdata = sram.wdata;
    end
  end

  // Monitor: every WB transfer is matched against the head of the scoreboard.
  wb_out_t exp_w;
  always @(negedge clk) begin
    #2;
    if (!reset && wb_valid && wb_allow_in) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wb_output: actual=0x%0h required=none", to_wb);
      end else begin
        exp_w = sb_q.pop_front();
        chk("wb_bundle", 70'(to_wb), 70'(exp_w));
        chk("fwd_value_at_wb", 70'(fwd_value), 70'(exp_w.final_result));
      end
    end
  end

  // Present a bundle from a negedge until accepted; returns at the following negedge.
  task automatic issue(input mem_in_t b, input logic [31:0] exp_final, output int acc_cyc);
    bit      done = 0;
    wb_out_t e;
    ex_valid = 1'b1;
    to_mem   = b;
    acc_cyc  = -1;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (mem_allow_in) begin
        done    = 1;
        acc_cyc = cyc;
        e.pc = b.pc; e.final_result = exp_final; e.dest = b.dest; e.gr_we = b.gr_we;
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL issue_timeout: actual=not_accepted required=accepted pc=0x%0h", b.pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, h0;
    reset = 1'b1; ex_valid = 1'b0; to_mem = '0; wb_allow_in = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("reset_wb_valid", 70'(wb_valid), 70'(0));
    chk("reset_req", 70'(sram.req), 70'(0));
    chk("reset_allow_in", 70'(mem_allow_in), 70'(1));
    chk("reset_fwd", 70'({fwd_valid, fwd_dest, fwd_value, fwd_stall}), 70'(0));
    chk("reset_wb_data", 70'(to_wb), 70'(0));
    @(negedge clk);
    reset = 1'b0;

    // ALU-only bundle: one-cycle latency, no memory request
    issue(mk(32'h100, 32'h1234, 32'h0, 1'b0, 1'b0, 5'd5, 1'b1), 32'h1234, c0);
    ex_valid = 1'b0;
    #2;
    chk("alu_valid", 70'(wb_valid), 70'(1));
    chk("alu_latency", 70'(cyc - c0), 70'(1));
    chk("alu_no_req", 70'(sram.req), 70'(0));
    chk("alu_fwd", 70'({fwd_valid, fwd_dest, fwd_stall}), 70'({1'b1, 5'd5, 1'b0}));
    @(negedge clk);

    // Load at unaligned 0x1003: addr_ok same cycle, data_ok next cycle
    addr_dly = 0; data_dly = 1; mem_rdata = 32'hDEAD_BEEF;
    issue(mk(32'h200, 32'h1003, 32'h0, 1'b0, 1'b1, 5'd7, 1'b1), 32'hDEAD_BEEF, c0);
    ex_valid = 1'b0;
    #2;
    chk("ld_req", 70'({sram.req, sram.wr, sram.addr}), 70'({1'b1, 1'b0, 32'h1000}));
    chk("ld_fwd_stall", 70'(fwd_stall), 70'(1));
    chk("ld_not_ready", 70'(wb_valid), 70'(0));
    @(negedge clk); #2;
    chk("ld_wait", 70'({wb_valid, sram.req}), 70'(0));
    @(negedge clk); #2;
    chk("ld_done_valid", 70'(wb_valid), 70'(1));
    chk("ld_latency", 70'(cyc - c0), 70'(3));
    @(negedge clk);

    // Store with addr_ok held off 3 cycles: req/addr/wdata stable, stage blocked until data_ok
    addr_dly = 3; data_dly = 1;
    issue(mk(32'h300, 32'h2000, 32'hA5A5_A5A5, 1'b1, 1'b0, 5'd0, 1'b0), 32'h2000, c0);
    ex_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("st_req_held", 70'({sram.req, sram.wr, sram.addr, sram.wdata}),
          70'({1'b1, 1'b1, 32'h2000, 32'hA5A5_A5A5}));
      chk("st_blocked", 70'(mem_allow_in), 70'(0));
      @(negedge clk);
    end
    #2;
    chk("st_wait", 70'({sram.req, mem_allow_in, wb_valid}), 70'(0));
    @(negedge clk); #2;
    chk("st_done", 70'({wb_valid, mem_allow_in}), 70'(2'b11));
    @(negedge clk);

    // Load completing while WB stalls for 3 cycles
    addr_dly = 0; data_dly = 1; mem_rdata = 32'h1357_9BDF; wb_allow_in = 1'b0;
    h0 = hs_count;
    issue(mk(32'h400, 32'h4008, 32'h0, 1'b0, 1'b1, 5'd9, 1'b1), 32'h1357_9BDF, c0);
    ex_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("stall_hold", 70'({wb_valid, sram.req, fwd_stall, mem_allow_in}), 70'(4'b1000));
      chk("stall_value", 70'(fwd_value), 70'(32'h1357_9BDF));
      @(negedge clk);
    end
    wb_allow_in = 1'b1;
    @(negedge clk);
    chk("stall_single_req", 70'(hs_count - h0), 70'(1));

    // Load followed immediately by an ALU op, slow data_ok
    data_dly = 4; mem_rdata = 32'h0BAD_F00D;
    issue(mk(32'h500, 32'h5000, 32'h0, 1'b0, 1'b1, 5'd10, 1'b1), 32'h0BAD_F00D, c0);
    issue(mk(32'h504, 32'h77, 32'h0, 1'b0, 1'b0, 5'd11, 1'b1), 32'h77, c1);
    ex_valid = 1'b0;
    chk("b2b_alu_after_load", 70'(c1 - c0), 70'(6));
    repeat (2) @(negedge clk);

    // Reset while waiting for data_ok
    data_dly = 5;
    issue(mk(32'h600, 32'h6000, 32'h0, 1'b0, 1'b1, 5'd12, 1'b1), 32'h0, c0);
    ex_valid = 1'b0;
    @(negedge clk); #2;
    chk("rst_pre_wait", 70'({wb_valid, sram.req, mem_allow_in}), 70'(0));
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk); #2;
    chk("rst_after", 70'({wb_valid, sram.req, mem_allow_in, fwd_valid}), 70'(4'b0010));
    @(negedge clk);
    reset = 1'b0;

    // Recovery after reset
    data_dly = 1;
    issue(mk(32'h700, 32'hCAFE, 32'h0, 1'b0, 1'b0, 5'd3, 1'b1), 32'hCAFE, c0);
    ex_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 70'(sb_q.size()), 70'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
